// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, STATUS bit positions and serializer state encoding
package mmio_pkg;
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO; push ignored when full, pop ignored when empty
// ports: clock/reset (async active-low), push/din in, pop/dout out, full/empty/count flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;
    assign full    = count_q == AW1'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rp_q];
    assign count   = count_q;
    always_ff @(posedge clock)
        if (do_push) mem_q[wp_q] <= din;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop) rp_q <= rp_q + AW'(1);
            count_q <= count_q + AW1'(do_push) - AW1'(do_pop);
        end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO
// ports: clock/reset (async active-low), address_dmem/data/wren from M stage,
//        sel (window hit), q_mmio (read data), tx (serial line, idle high)
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic        sel,
    output logic [31:0] q_mmio,
    output logic        tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    logic [1:0]    off;
    logic          wr_en, push, pop, full, empty, bit_end, ovf_q, tx_q;
    logic [7:0]    dout, shift_q;
    logic [AW:0]   count;
    logic [31:0]   status;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    idx_q;
    tx_state_e     state_q;
    logic          unused_data;
    assign unused_data = ^data[31:8];
    assign off     = address_dmem[1:0];
    assign sel     = address_dmem[31:2] == BASE_ADDR[31:2];
    assign wr_en   = sel && wren;
    assign push    = wr_en && off == REG_TXDATA;
    assign bit_end = bit_cnt_q == BIT_LAST;
    // pop only when the serializer is ready for a new byte: idle, or the last stop-bit cycle
    assign pop     = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
    assign tx      = tx_q;
    assign q_mmio  = off == REG_STATUS ? status : '0;
    always_comb begin
        status                = '0;
        status[ST_FULL]       = full;
        status[ST_EMPTY]      = empty;
        status[ST_BUSY]       = state_q != IDLE;
        status[ST_OVF]        = ovf_q;
        status[ST_COUNT +: 8] = 8'(count);
    end
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(data[7:0]),
        .dout(dout),
        .full(full),
        .empty(empty),
        .count(count)
    );
    // a dropped push (full) sets overflow and takes priority over a clear
    always_ff @(posedge clock or negedge reset)
        if (!reset) ovf_q <= 1'b0;
        else if (push && full) ovf_q <= 1'b1;
        else if (wr_en && off == REG_STATUS && data[ST_OVF]) ovf_q <= 1'b0;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE:
                    if (pop) begin
                        state_q   <= START;
                        shift_q   <= dout;
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                        tx_q      <= 1'b0;
                    end
                START:
                    if (!bit_end) bit_cnt_q <= bit_cnt_q + CW'(1);
                    else begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                DATA:
                    if (!bit_end) bit_cnt_q <= bit_cnt_q + CW'(1);
                    else begin
                        bit_cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shift_q[idx_q + 3'd1];
                        end
                    end
                STOP:
                    if (!bit_end) bit_cnt_q <= bit_cnt_q + CW'(1);
                    else begin
                        bit_cnt_q <= '0;
                        if (pop) begin
                            state_q <= START;
                            shift_q <= dout;
                            idx_q   <= '0;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end
            endcase
        end
endmodule
